// File: rtl/demux_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_sched_pkg
//  Brief    : Shared state encoding, destination count and index helpers
//             for the demux_sched round-robin demultiplexer.
//  Revision : 1.0  initial release
// ============================================================================
package demux_sched_pkg;

    localparam int NUM_DST = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Destination indices wrap naturally from 3 to 0 in SEL_W bits.
    function automatic logic [SEL_W-1:0] next_dst(input logic [SEL_W-1:0] idx);
        return SEL_W'(idx + 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_sched_dst_decode.sv
`default_nettype none
// ============================================================================
//  Module   : dst_decode
//  Brief    : 2-to-4 one-hot decoder with enable, drives per-destination valid.
//  Revision : 1.0  initial release
// ============================================================================
module dst_decode
    import demux_sched_pkg::*;
(
    input  logic               i_en,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [NUM_DST-1:0] o_onehot
);

    for (genvar gi = 0; gi < NUM_DST; gi++) begin : g_dec
        assign o_onehot[gi] = i_en && (i_sel == SEL_W'(gi));
    end

endmodule
`default_nettype wire

// File: rtl/demux_sched.sv
`default_nettype none
// ============================================================================
//  Module   : demux_sched
//  Brief    : Single-word round-robin demux to 4 destinations with optional
//             stall timeout / skip / drop (enabled by DEMUX_SCHED_TIMEOUT_EN).
//  Revision : 1.0  initial release
// ============================================================================
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DW-1:0]      in_data,
    output logic               in_ready,
    output logic [NUM_DST-1:0] out_valid,
    output logic [DW-1:0]      out_data,
    input  logic [NUM_DST-1:0] out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               drop
);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [DW-1:0]    r_hold, w_hold_nxt;
    logic             w_ready_sel;
    logic             w_timeout;
    logic             w_last_skip;

    assign w_ready_sel = out_ready[r_sel];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_hold_nxt  = in_data;
                    w_sel_nxt   = r_ptr;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                // A ready on the timeout cycle has priority over the skip.
                if (w_ready_sel) begin
                    w_ptr_nxt   = next_dst(r_sel);
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    if (w_last_skip) begin
                        w_ptr_nxt   = next_dst(r_sel);
                        w_state_nxt = IDLE;
                    end else begin
                        w_sel_nxt = next_dst(r_sel);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam logic [7:0] c_timeout_m1 = 8'(TIMEOUT - 1);

    logic [7:0]       r_wait, w_wait_nxt;
    logic [SEL_W-1:0] r_skip, w_skip_nxt;

    // r_wait counts stalled cycles already seen on the current destination.
    assign w_timeout   = (r_wait == c_timeout_m1);
    assign w_last_skip = (r_skip == SEL_W'(NUM_DST - 1));
    assign drop        = (r_state == SEND) && !w_ready_sel && w_timeout && w_last_skip;

    always_comb begin
        w_wait_nxt = r_wait;
        w_skip_nxt = r_skip;
        if (r_state == IDLE) begin
            if (in_valid) begin
                w_wait_nxt = '0;
                w_skip_nxt = '0;
            end
        end else if (!w_ready_sel) begin
            if (w_timeout) begin
                w_wait_nxt = '0;
                w_skip_nxt = SEL_W'(r_skip + 1'b1);
            end else begin
                w_wait_nxt = r_wait + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
            r_skip <= '0;
        end else begin
            r_wait <= w_wait_nxt;
            r_skip <= w_skip_nxt;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_last_skip = 1'b0;
    assign drop        = 1'b0;
`endif

    assign in_ready = (r_state == IDLE);
    assign out_data = r_hold;
    assign sel      = r_sel;

    dst_decode u_dst_decode (
        .i_en     (r_state == SEND),
        .i_sel    (r_sel),
        .o_onehot (out_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_demux_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_sched
//  Brief    : Directed self-checking bench for demux_sched with a cycle-level
//             reference model and hand-computed checkpoints.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_sched;

    localparam int TIMEOUT = 15;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ready;
    logic [1:0] sel;
    logic       drop;

    int n_tests = 0;
    int n_fail  = 0;

    demux_sched #(.DW(8), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one word in flight, targeted destination, the cycle at
    // which that destination started being targeted, and how many were skipped.
    bit         m_busy  = 1'b0;
    int         m_dst   = 0;
    int         m_ptr   = 0;
    int         m_start = 0;
    int         m_tried = 0;
    int         m_cyc   = 0;
    logic [7:0] m_word  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_dst   = 0;
            m_ptr   = 0;
            m_tried = 0;
            m_start = 0;
            m_word  = '0;
        end else begin
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy  = 1'b1;
                    m_word  = in_data;
                    m_dst   = m_ptr;
                    m_tried = 0;
                    m_start = m_cyc + 1;
                end
            end else if (out_ready[m_dst]) begin
                m_busy = 1'b0;
                m_ptr  = (m_dst + 1) % 4;
            end else if (TO_EN && (m_cyc - m_start + 1 == TIMEOUT)) begin
                if (m_tried == 3) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_dst + 1) % 4;
                end else begin
                    m_tried++;
                    m_dst   = (m_dst + 1) % 4;
                    m_start = m_cyc + 1;
                end
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", in_ready, !m_busy);
        chk("cyc_out_valid", out_valid, m_busy ? (32'd1 << m_dst) : 32'd0);
        chk("cyc_out_data", out_data, m_word);
        chk("cyc_sel", sel, m_dst);
        chk("cyc_drop", drop, TO_EN && m_busy && !out_ready[m_dst] &&
                              (m_cyc - m_start + 1 == TIMEOUT) && (m_tried == 3));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && !in_ready; i++) tick(1);
        chk("wait_idle", in_ready, 1);
    endtask

    // Leaves the bench at posedge+1 of the first SEND cycle.
    task automatic send_word(input logic [7:0] d);
        wait_idle(200);
        in_valid = 1'b1;
        in_data  = d;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_fast(input logic [7:0] d, input logic [3:0] exp_valid);
        out_ready = 4'hF;
        send_word(d);
        chk("fast_valid", out_valid, exp_valid);
        chk("fast_data", out_data, d);
        chk("fast_in_ready_send", in_ready, 0);
        tick(1);
        chk("fast_in_ready_idle", in_ready, 1);
    endtask

    initial begin
        int drops;
        logic seen;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_drop", drop, 0);
        chk("rst_out_data", out_data, 0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Round-robin with every destination ready: 0,1,2,3 then back to 0.
        for (int i = 0; i < 5; i++)
            send_fast(8'h11 + 8'(i), 4'b0001 << (i % 4));

`ifdef DEMUX_SCHED_TIMEOUT_EN
        // ptr=1, destination 1 stalled: skip to 2 after 15 cycles.
        out_ready = 4'b1101;
        send_word(8'h3C);
        chk("B_sel_c1", sel, 1);
        chk("B_valid_c1", out_valid, 4'b0010);
        tick(14);
        chk("B_sel_c15", sel, 1);
        tick(1);
        chk("B_sel_c16", sel, 2);
        chk("B_valid_c16", out_valid, 4'b0100);
        chk("B_data_c16", out_data, 8'h3C);
        tick(1);
        chk("B_idle", in_ready, 1);

        // ptr=3, ready arrives on the 15th stalled cycle and wins.
        out_ready = 4'b0000;
        send_word(8'h5A);
        chk("C_sel_c1", sel, 3);
        tick(14);
        out_ready = 4'b1000;
        chk("C_sel_c15", sel, 3);
        chk("C_drop_c15", drop, 0);
        tick(1);
        chk("C_idle", in_ready, 1);
        chk("C_sel_after", sel, 3);

        // ptr=0, nothing ever ready: sel walks 0..3, drop on SEND cycle 60.
        out_ready = 4'b0000;
        send_word(8'h7E);
        drops = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 1 || c == 16 || c == 31 || c == 46)
                chk("D_sel_step", sel, (c - 1) / 15);
            if (drop) drops++;
            if (c == 60) chk("D_drop_c60", drop, 1);
            else tick(1);
        end
        tick(1);
        chk("D_idle", in_ready, 1);
        chk("D_drop_after", drop, 0);
        chk("D_drop_count", drops, 1);
        send_fast(8'h99, 4'b0001);
        send_fast(8'h01, 4'b0010);
`else
        // ptr=1: bring ptr to 0, then stall destination 0 for 100 cycles.
        send_fast(8'h21, 4'b0010);
        send_fast(8'h22, 4'b0100);
        send_fast(8'h23, 4'b1000);
        out_ready = 4'b0000;
        send_word(8'h42);
        seen = 1'b0;
        for (int c = 1; c < 100; c++) begin
            if (sel != 2'd0 || drop) seen = 1'b1;
            tick(1);
        end
        chk("F_sel", sel, 0);
        chk("F_any_skip_or_drop", seen, 0);
        chk("F_valid", out_valid, 4'b0001);
        chk("F_data", out_data, 8'h42);
        out_ready = 4'b0001;
        tick(1);
        chk("F_idle", in_ready, 1);
        send_fast(8'h01, 4'b0010);
`endif

        // ptr=2: hold 0xA5 for destination 2, then reset mid-cycle.
        out_ready = 4'b0000;
        send_word(8'hA5);
        tick(3);
        chk("E_sel", sel, 2);
        chk("E_data", out_data, 8'hA5);
        chk("E_valid", out_valid, 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk("E_rst_valid", out_valid, 0);
        chk("E_rst_in_ready", in_ready, 1);
        chk("E_rst_sel", sel, 0);
        chk("E_rst_drop", drop, 0);
        chk("E_rst_data", out_data, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("E_post_idle", in_ready, 1);
        send_fast(8'h5C, 4'b0001);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
